// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption engine, one round per clock.
// Round keys are fetched from an external store via rk_idx.
module aes_encrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   switch,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   nr_q, nr_d;
    logic [127:0] round_out;
    logic         last;
    logic [7:0]   sr [4][4];
    logic [7:0]   mc [4][4];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign last = (cnt_q == nr_q);

    // Byte (r,c) sits at bits 127-8*(4c+r); ShiftRows reads column c+r.
    always_comb begin
        round_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r][c] = SBOX[state_q[127-8*(4*((c+r)%4)+r) -: 8]];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[0][c] = xt(sr[0][c]) ^ xt(sr[1][c]) ^ sr[1][c]
                     ^ sr[2][c] ^ sr[3][c];
            mc[1][c] = sr[0][c] ^ xt(sr[1][c]) ^ xt(sr[2][c])
                     ^ sr[2][c] ^ sr[3][c];
            mc[2][c] = sr[0][c] ^ sr[1][c] ^ xt(sr[2][c])
                     ^ xt(sr[3][c]) ^ sr[3][c];
            mc[3][c] = xt(sr[0][c]) ^ sr[0][c] ^ sr[1][c]
                     ^ sr[2][c] ^ xt(sr[3][c]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                round_out[127-8*(4*c+r) -: 8] =
                    (last ? sr[r][c] : mc[r][c])
                    ^ rk[127-8*(4*c+r) -: 8];
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        ct_d    = ct_q;
        cnt_d   = cnt_q;
        nr_d    = nr_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    unique case (switch)
                        2'b00:   nr_d = 4'd10;
                        2'b01:   nr_d = 4'd12;
                        default: nr_d = 4'd14;
                    endcase
                    state_d = pt ^ rk;
                    cnt_d   = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                cnt_d   = cnt_q + 4'd1;
                if (last) begin
                    ct_d  = round_out;
                    cnt_d = 4'd0;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            ct_q    <= '0;
            cnt_q   <= '0;
            nr_q    <= 4'd10;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            ct_q    <= ct_d;
            cnt_q   <= cnt_d;
            nr_q    <= nr_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign rk_idx    = (fsm_q == RUN) ? cnt_q : 4'd0;
    assign ct        = ct_q;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for aes_encrypt_iter with FIPS-197 vectors.
// Round keys come from a key-expansion model driven by rk_idx.
module tb_aes_encrypt_iter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   switch;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;

    aes_encrypt_iter dut (
        .clk(clk), .rst_n(rst_n), .switch(switch),
        .in_valid(in_valid), .in_ready(in_ready), .pt(pt),
        .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
        .out_ready(out_ready), .ct(ct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ct;
        int           nr;
        int           acc;
    } exp_t;

    exp_t         sbq[$];
    logic [7:0]   sb [256];
    logic [127:0] rks [16];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_acc = 0;
    int           last_nr = 0;
    bit           ov_prev = 1'b0;

    localparam logic [255:0] KEY_B =
        256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
    localparam logic [255:0] KEY_C =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C2 = 128'h8ea2b7ca516745bfeafc49904b496089;

    assign rk = rks[rk_idx];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from GF(2^8) inverse plus affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3)
                  ^ rol(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 16; j++)
            rks[j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]}
                               : 128'h0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [127:0] p, input logic [255:0] key,
                         input logic [1:0] sw, input logic [127:0] exp,
                         input bit keep, input bit b2b);
        bit   ok = 1'b0;
        int   nk;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1");
            return;
        end
        chk("rk_idx_idle", 128'(rk_idx), 128'd0);
        nk = (sw == 2'b00) ? 4 : (sw == 2'b01) ? 6 : 8;
        switch = sw;
        pt = p;
        expand(key, nk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        e.ct = exp;
        e.nr = nk + 6;
        e.acc = cyc;
        sbq.push_back(e);
        if (b2b) chk("b2b_spacing", 128'(cyc - last_acc), 128'(last_nr + 2));
        last_acc = cyc;
        last_nr = nk + 6;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sbq.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got ct %h expected none", ct);
                end else begin
                    e = sbq.pop_front();
                    chk("ct", ct, e.ct);
                    chk("latency", 128'(cyc - e.acc), 128'(e.nr));
                    chk("in_ready_done", 128'(in_ready), 128'd0);
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        build_sbox();
        rst_n = 1'b0;
        switch = 2'b00;
        in_valid = 1'b0;
        pt = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) rks[j] = '0;
        #12;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_ct", ct, 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(PT_B, KEY_B, 2'b00, CT_B, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("rk_idx_seq", 128'(rk_idx), 128'(k));
        end
        drain();

        issue(PT_C, KEY_C, 2'b00, CT_C0, 1'b0, 1'b0);
        drain();
        issue(PT_C, KEY_C, 2'b01, CT_C1, 1'b0, 1'b0);
        drain();
        issue(PT_C, KEY_C, 2'b10, CT_C2, 1'b0, 1'b0);
        drain();
        issue(PT_C, KEY_C, 2'b11, CT_C2, 1'b0, 1'b0);
        drain();

        out_ready = 1'b0;
        issue(PT_C, KEY_C, 2'b00, CT_C0, 1'b0, 1'b0);
        in_valid = 1'b1;
        pt = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL bp_wait: got out_valid=0 expected 1");
        end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_ct", ct, CT_C0);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ov", 128'(out_valid), 128'd0);
        chk("bp_release_ir", 128'(in_ready), 128'd1);
        chk("bp_ct_hold", ct, CT_C0);
        issue(PT_B, KEY_B, 2'b00, CT_B, 1'b0, 1'b0);
        drain();

        issue(PT_C, KEY_C, 2'b00, CT_C0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 switch = 2'b10;
        drain();
        switch = 2'b00;

        issue(PT_B, KEY_B, 2'b00, CT_B, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_ct", ct, 128'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(PT_B, KEY_B, 2'b00, CT_B, 1'b0, 1'b0);
        drain();

        issue(PT_B, KEY_B, 2'b00, CT_B, 1'b1, 1'b0);
        issue(PT_C, KEY_C, 2'b01, CT_C1, 1'b1, 1'b1);
        issue(PT_C, KEY_C, 2'b10, CT_C2, 1'b1, 1'b1);
        issue(PT_C, KEY_C, 2'b00, CT_C0, 1'b0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
